// File: rtl/m_ps2_kbd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// m_ps2_kbd : PS/2 keyboard receiver with scancode FIFO and 16-bit bus port
// Rev 1.0
// ============================================================================
module m_ps2_kbd #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        ps2c_i,
  input  logic        ps2d_i,
  input  logic [15:0] dat_dat_i,
  input  logic        dat_we_i,
  input  logic        dat_cyc_i,
  input  logic        dat_stb_i,
  output logic [15:0] dat_dat_o,
  output logic        dat_ack_o
);

  localparam int C_FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int C_TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int C_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int C_CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [C_FILT_W-1:0] C_FILT_LAST = C_FILT_W'(FILTER_LEN - 1);
  localparam logic [C_TMO_W-1:0]  C_TMO_LAST  = C_TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [C_CNT_W-1:0]  C_FULL_CNT  = C_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // synchronizers and clock filter
  logic                ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
  logic                ps2c_filt_q, ps2c_filt_d;
  logic [C_FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic                fall_w;

  // receiver
  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [C_TMO_W-1:0]  tmo_q, tmo_d;
  logic                push_w, frame_err_w;

  // FIFO, flags and bus
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [C_PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0]  count_q, count_d;
  logic                ovf_q, ovf_d, err_q, err_d;
  logic                ack_q, ack_d;
  logic [15:0]         dat_q, dat_d;
  logic                req_w, rd_req_w, wr_req_w;
  logic                valid_w, full_w, pop_w, clr_w, push_ok_w, ovf_set_w;
  logic                unused_bits_w;

  assign unused_bits_w = ^{dat_dat_i[15], dat_dat_i[12:1]};

  // The filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    ps2c_filt_d = ps2c_filt_q;
    filt_cnt_d  = '0;
    if (ps2c_s2_q != ps2c_filt_q) begin
      if (filt_cnt_q == C_FILT_LAST) begin
        ps2c_filt_d = ps2c_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + C_FILT_W'(1);
      end
    end
    fall_w = ps2c_filt_q & ~ps2c_filt_d;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_d       = '0;
    push_w      = 1'b0;
    frame_err_w = 1'b0;
    if ((state_q != ST_IDLE) && !fall_w) begin
      tmo_d = tmo_q + C_TMO_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (fall_w && !ps2d_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall_w) begin
          shift_d   = {ps2d_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall_w) begin
          parity_d = ps2d_s2_q;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_w) begin
          if (ps2d_s2_q && (^{shift_q, parity_q})) begin
            push_w = 1'b1;
          end else begin
            frame_err_w = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // An abandoned partial frame is discarded silently, without touching flags.
    if ((state_q != ST_IDLE) && !fall_w && (tmo_q == C_TMO_LAST)) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      parity_d  = 1'b0;
      tmo_d     = '0;
    end
  end

  always_comb begin
    req_w     = dat_cyc_i & dat_stb_i & ~ack_q;
    rd_req_w  = req_w & ~dat_we_i;
    wr_req_w  = req_w & dat_we_i;
    valid_w   = (count_q != '0);
    full_w    = (count_q == C_FULL_CNT);
    pop_w     = rd_req_w & valid_w;
    clr_w     = wr_req_w & dat_dat_i[0];
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    push_ok_w = push_w & (~full_w | pop_w) & ~clr_w;
    ovf_set_w = push_w & full_w & ~pop_w;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_w) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_w) wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      if (pop_w)     rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      case ({push_ok_w, pop_w})
        2'b10:   count_d = count_q + C_CNT_W'(1);
        2'b01:   count_d = count_q - C_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // Hardware set wins over a same-cycle software clear.
    ovf_d = (ovf_q & ~(wr_req_w & dat_dat_i[14])) | ovf_set_w;
    err_d = (err_q & ~(wr_req_w & dat_dat_i[13])) | frame_err_w;

    ack_d = req_w;
    dat_d = 16'h0000;
    if (rd_req_w) begin
      dat_d = {valid_w, ovf_q, err_q, 5'b00000, (valid_w ? mem_q[rd_ptr_q] : 8'h00)};
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      ps2c_s1_q   <= 1'b1;
      ps2c_s2_q   <= 1'b1;
      ps2d_s1_q   <= 1'b1;
      ps2d_s2_q   <= 1'b1;
      ps2c_filt_q <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= 16'h0000;
    end else begin
      ps2c_s1_q   <= ps2c_i;
      ps2c_s2_q   <= ps2c_s1_q;
      ps2d_s1_q   <= ps2d_i;
      ps2d_s2_q   <= ps2d_s1_q;
      ps2c_filt_q <= ps2c_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge sys_clk_i) begin
    if (push_ok_w) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign dat_ack_o = ack_q;
  assign dat_dat_o = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_m_ps2_kbd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_m_ps2_kbd : randomized + directed bench against a queue-based model
// Rev 1.0
// ============================================================================
module tb_m_ps2_kbd;

  localparam int FL    = 8;
  localparam int TMO   = 600;
  localparam int DEPTH = 8;
  localparam int HP    = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps2c, ps2d;
  logic [15:0] dat_i;
  logic        we, cyc, stb;
  logic [15:0] dat_o;
  logic        ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mq[$];
  bit         m_ovf, m_err;

  always #5 clk = ~clk;

  m_ps2_kbd #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TMO),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst_n),
    .ps2c_i   (ps2c),
    .ps2d_i   (ps2d),
    .dat_dat_i(dat_i),
    .dat_we_i (we),
    .dat_cyc_i(cyc),
    .dat_stb_i(stb),
    .dat_dat_o(dat_o),
    .dat_ack_o(ack)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit par_ok, input bit stop);
    if (stop && par_ok) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  function automatic logic [15:0] model_read();
    logic [15:0] r;
    if (mq.size() > 0) begin
      r = {1'b1, m_ovf, m_err, 5'b00000, mq[0]};
      void'(mq.pop_front());
    end else begin
      r = {1'b0, m_ovf, m_err, 13'h0000};
    end
    return r;
  endfunction

  function automatic void model_write(input logic [15:0] w);
    if (w[14]) m_ovf = 1'b0;
    if (w[13]) m_err = 1'b0;
    if (w[0])  mq.delete();
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk); ps2d = b;
    wait_clk(5);
    @(negedge clk); ps2c = 1'b0;
    wait_clk(HP);
    @(negedge clk); ps2c = 1'b1;
    wait_clk(HP);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par_ok ? ~^b : ^b);
    ps2_bit(stop);
    ps2d = 1'b1;
    wait_clk(20);
    model_frame(b, par_ok, stop);
  endtask

  task automatic send_partial(input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2d = 1'b1;
    wait_clk(TMO + 100);
  endtask

  task automatic bus_xfer(input logic w, input logic [15:0] wd, output logic [15:0] rd);
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = w; dat_i = wd;
    @(negedge clk);
    check_val("ack_pulse", {15'd0, ack}, 16'h0001);
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_i = 16'h0000;
    @(negedge clk);
    check_val("ack_low", {15'd0, ack}, 16'h0000);
  endtask

  task automatic bus_read(input string tag);
    logic [15:0] rd;
    bus_xfer(1'b0, 16'h0000, rd);
    check_val(tag, rd, model_read());
  endtask

  task automatic bus_write(input string tag, input logic [15:0] wd);
    logic [15:0] rd;
    bus_xfer(1'b1, wd, rd);
    check_val(tag, rd, 16'h0000);
    model_write(wd);
  endtask

  task automatic drain(input string tag);
    int n;
    n = mq.size();
    for (int i = 0; i <= n; i++) bus_read(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [15:0] wd;
    int op;

    rst_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1;
    dat_i = 16'h0000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    model_reset();
    wait_clk(3);
    #1;
    check_val("rst_ack", {15'd0, ack}, 16'h0000);
    check_val("rst_dat", dat_o, 16'h0000);
    @(negedge clk); cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
    wait_clk(3);
    bus_read("rst_empty");

    // valid frame, then read, then empty read
    send_frame(8'h1C, 1'b1, 1'b1);
    bus_read("v1c_read");
    bus_read("v1c_empty");

    // bad parity sets ERR; cleared by write
    send_frame(8'h1C, 1'b0, 1'b1);
    bus_read("par_err");
    bus_write("clr_err_w", 16'h2000);
    bus_read("par_err_clr");

    // overflow after nine frames
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b1);
    drain("ovf_drain");
    bus_write("clr_ovf_w", 16'h4000);
    bus_read("ovf_clr");

    // partial frame abandoned by timeout
    send_partial(3);
    send_frame(8'h5A, 1'b1, 1'b1);
    bus_read("tmo_5a");
    bus_read("tmo_empty");

    // short low glitch with data low must not start a frame
    @(negedge clk); ps2d = 1'b0; ps2c = 1'b0;
    wait_clk(3);
    @(negedge clk); ps2c = 1'b1; ps2d = 1'b1;
    wait_clk(2);
    send_frame(8'h33, 1'b1, 1'b1);
    bus_read("glitch_33");

    // held strobe on empty FIFO acks every second cycle
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("held_ack", {15'd0, ack}, (i % 2 == 0) ? 16'h0001 : 16'h0000);
    end
    cyc = 1'b0; stb = 1'b0;
    wait_clk(2);
    bus_read("held_empty");

    // read near the push with four entries
    for (int i = 0; i < 4; i++) send_frame(8'h40 + 8'(i), 1'b1, 1'b1);
    fork
      send_frame(8'h77, 1'b1, 1'b1);
      begin
        repeat (11) @(negedge ps2c);
        wait_clk(FL);
        bus_read("pp_head");
      end
    join
    drain("pp_drain");

    // write with bit 0 empties the FIFO
    send_frame(8'h12, 1'b1, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    bus_write("flush_w", 16'h0001);
    bus_read("flush_empty");

    // reset drops a pending ack
    @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("rst_ack_drop", {15'd0, ack}, 16'h0000);
    check_val("rst_dat_drop", dat_o, 16'h0000);
    cyc = 1'b0; stb = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    wait_clk(2);

    // reset mid-frame after the fifth data bit
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    @(negedge clk); rst_n = 1'b0;
    wait_clk(3);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    wait_clk(2);
    send_frame(8'h29, 1'b1, 1'b1);
    bus_read("rst_mid_29");

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 11));
      b  = 8'($urandom_range(0, 255));
      if (op <= 4)       send_frame(b, 1'b1, 1'b1);
      else if (op == 5)  send_frame(b, 1'b0, 1'b1);
      else if (op == 6)  send_frame(b, 1'b1, 1'b0);
      else if (op <= 9)  bus_read("rnd_read");
      else if (op == 10) begin
        wd = 16'h0000;
        wd[14] = 1'($urandom_range(0, 1));
        wd[13] = 1'($urandom_range(0, 1));
        wd[0]  = ($urandom_range(0, 3) == 0);
        bus_write("rnd_write", wd);
      end else begin
        send_partial(int'($urandom_range(1, 8)));
      end
    end
    drain("rnd_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_ps2_kbd.md
M_PS2_KBD -- requirements
Module: m_ps2_kbd

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: ps2c_i cycles a level must hold stable before it is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: idle cycles (2 ms at 25 MHz) after which a partial frame is abandoned.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two): scancode FIFO entries.
REQ-004 sys_clk_i  in  1  system clock (25 MHz).
REQ-005 sys_rst_i  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 ps2c_i  in  1  PS/2 clock from keyboard, asynchronous.
REQ-007 ps2d_i  in  1  PS/2 data from keyboard, asynchronous.
REQ-008 dat_dat_i  in  16  CPU write data.
REQ-009 dat_we_i  in  1  1 = write, 0 = read.
REQ-010 dat_cyc_i  in  1  bus cycle in progress.
REQ-011 dat_stb_i  in  1  strobe, already decoded for address $FFFE.
REQ-012 dat_dat_o  out  16  read data, registered.
REQ-013 dat_ack_o  out  1  transfer acknowledge, registered.

Function
REQ-014 ps2c_i and ps2d_i SHALL each pass through a two-flop synchronizer before any use.
REQ-015 Filtered PS/2 clock SHALL change only after FILTER_LEN consecutive equal synchronized samples; a falling edge is a filtered 1->0 transition.
REQ-016 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP; ps2d is sampled only on filtered falling edges.
REQ-017 IDLE: edge with data 0 -> DATA with bit count 0; edge with data 1 -> stay IDLE.
REQ-018 DATA: shift bit into shift register LSB-first; after the 8th bit -> PARITY.
REQ-019 PARITY: capture parity bit -> STOP.
REQ-020 STOP: if stop bit = 1 and the 9 bits (data + parity) hold an odd count of ones, push the byte; otherwise set the sticky ERR flag and push nothing; then -> IDLE.
REQ-021 In any state other than IDLE, TIMEOUT_CYC cycles without a falling edge SHALL force IDLE, discard the partial byte, and leave flags unchanged.
REQ-022 Push into a full FIFO SHALL drop the byte, keep existing contents, and set the sticky OVF flag.
REQ-023 Bus handshake: dat_ack_o SHALL be 1 in the cycle after a cycle with dat_cyc_i & dat_stb_i & ~dat_ack_o, otherwise 0. This gives a one-cycle pulse; a held strobe acks every second cycle.
REQ-024 Read: in the ack cycle, dat_dat_o SHALL be {VALID, OVF, ERR, 5'b0, head byte}, with fields sampled in the request cycle. VALID = FIFO not empty; the byte field is 0 when the FIFO is empty.
REQ-025 A read with VALID = 1 SHALL pop one entry at the request-cycle edge; a read of an empty FIFO SHALL have no side effect.
REQ-026 Write: dat_dat_i[14] = 1 clears OVF; dat_dat_i[13] = 1 clears ERR; dat_dat_i[0] = 1 empties the FIFO. dat_dat_o SHALL read 0 in a write ack cycle.
REQ-027 Push and pop in the same cycle SHALL both take effect: count unchanged, even when the FIFO is full.
REQ-028 A flag set by hardware and cleared by a bus write in the same cycle SHALL end set.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.

Reset
REQ-030 While sys_rst_i = 0, the following SHALL be held regardless of clock:
- FSM in IDLE; bit count, shift register and timeout counter = 0.
- FIFO empty; OVF = ERR = 0.
- Filter and synchronizer outputs = 1.
- dat_ack_o = 0 and dat_dat_o = 0.
REQ-031 Reset asserted mid-frame or mid-bus-cycle SHALL abort the frame, drop any pending ack, and need no cleanup afterward.

Verification
REQ-032 Valid frame 0x1C (parity 0, stop 1), then a read -> ack one cycle later with 0x801C; a second read -> 0x0000.
REQ-033 Frame 0x1C with parity 1 -> read 0x2000; write 0x2000 -> next read 0x0000.
REQ-034 Nine frames 0x01..0x09 with no reads -> reads return 0xC001 .. 0xC008, then 0x4000; write 0x4000 -> 0x0000.
REQ-035 Start bit plus 3 data bits, then 3 ms idle, then valid frame 0x5A -> read 0x805A; ERR stays 0.
REQ-036 A 3-cycle low glitch on ps2c_i during IDLE -> no FSM change. A pop and a push in the same cycle with 4 entries -> count stays 4, order preserved.
REQ-037 Reset pulsed after the 5th data bit, then frame 0x29 -> read 0x8029.
